hazard_scoreboard_unit: RTL and testbench

Parametrised next-generation hazard unit for the 5-stage RISC-V pipeline. It adds three things to combinational forwarding, load-use and branch hazard detection:
- a per-register busy scoreboard for a single iterative divider that writes back out of order;
- a data-memory ready handshake that freezes the whole pipe;
- optional saturating stall/flush performance counters.

It sits beside the datapath and drives every stage's stall/flush enables and the E- and D-stage forwarding muxes.

---
 rtl/hazard_scoreboard_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipe: forwarding, load-use, branch, memory-freeze and divider scoreboard.
// Optional saturating stall/flush counters are built when HAZARD_PERF_CNT_EN is defined.

module hsu_fwd_lane #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_e_i,
    input  logic [REG_AW-1:0] rs_d_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              wr_m_i,
    input  logic              wr_w_i,
    output logic [1:0]        fwd_e_o,
    output logic              fwd_d_o
);
    always_comb begin
        fwd_e_o = 2'b00;
        if (wr_m_i && rs_e_i == rd_m_i && rs_e_i != '0)
            fwd_e_o = 2'b10;
        else if (wr_w_i && rs_e_i == rd_w_i && rs_e_i != '0)
            fwd_e_o = 2'b01;
    end

    assign fwd_d_o = wr_w_i && rs_d_i == rd_w_i && rs_d_i != '0;
endmodule

`ifdef HAZARD_PERF_CNT_EN
module hsu_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (inc_i && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o = cnt_q;
endmodule
`endif

module hazard_scoreboard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              IsDivD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              PCSrcE,
    input  logic              ResultSrcE0,
    input  logic              DivStartE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    input  logic              DivValidW,
    input  logic [REG_AW-1:0] DivRdW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              Forwardr1D,
    output logic              Forwardr2D,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic [CNT_W-1:0]  LoadStallCnt,
    output logic [CNT_W-1:0]  DivStallCnt,
    output logic [CNT_W-1:0]  MemStallCnt,
    output logic [CNT_W-1:0]  FlushCnt,
    output logic              DivBusy
);
    localparam int NUM_REGS = 2 ** REG_AW;

    // ---------------- forwarding, one lane per source operand ----------------
    logic [1:0][REG_AW-1:0] rs_e, rs_d;
    logic [1:0][1:0]        fwd_e;
    logic [1:0]             fwd_d;

    assign rs_e = {Rs2E, Rs1E};
    assign rs_d = {Rs2D, Rs1D};

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        hsu_fwd_lane #(.REG_AW(REG_AW)) u_lane (
            .rs_e_i  (rs_e[g]),
            .rs_d_i  (rs_d[g]),
            .rd_m_i  (RdM),
            .rd_w_i  (RdW),
            .wr_m_i  (RegWriteM),
            .wr_w_i  (RegWriteW),
            .fwd_e_o (fwd_e[g]),
            .fwd_d_o (fwd_d[g])
        );
    end

    assign ForwardAE  = fwd_e[0];
    assign ForwardBE  = fwd_e[1];
    assign Forwardr1D = fwd_d[0];
    assign Forwardr2D = fwd_d[1];

    // ---------------- divider scoreboard ----------------
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                div_busy_q, div_busy_d;
    logic [NUM_REGS-1:0] sb_busy;
    logic                sb_div;
    logic                div_accept;

    // Scoreboard reads are masked while reset is held so stale state never stalls.
    assign sb_busy = busy_q & {NUM_REGS{rst_n}};
    assign sb_div  = div_busy_q & rst_n;

    // A start while busy is illegal upstream; dropping it keeps the scoreboard consistent.
    assign div_accept = DivStartE && !StallE && !div_busy_q;

    always_comb begin
        busy_d     = busy_q;
        div_busy_d = div_busy_q;
        if (DivValidW) begin
            div_busy_d     = 1'b0;
            busy_d[DivRdW] = 1'b0;
        end
        if (div_accept) begin
            div_busy_d  = 1'b1;
            busy_d[RdE] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q     <= '0;
            div_busy_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            div_busy_q <= div_busy_d;
        end
    end

    assign DivBusy = div_busy_q;

    // ---------------- hazard detection ----------------
    logic mem_stall, load_hz, div_hz;
    logic div_hz_sb, div_hz_fly, div_hz_issue;

    assign mem_stall = MemReqM && !MemReadyM;
    assign load_hz   = ResultSrcE0 && RdE != '0 && (Rs1D == RdE || Rs2D == RdE);

    assign div_hz_sb    = sb_busy[Rs1D] || sb_busy[Rs2D] || (RegWriteD && sb_busy[RdD]);
    // Covers the cycle before the busy bit becomes visible.
    assign div_hz_fly   = DivStartE && RdE != '0 &&
                          (RdE == Rs1D || RdE == Rs2D || (RegWriteD && RdE == RdD));
    assign div_hz_issue = IsDivD && (sb_div || DivStartE);
    assign div_hz       = div_hz_sb || div_hz_fly || div_hz_issue;

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_hz || div_hz) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // ---------------- performance counters ----------------
`ifdef HAZARD_PERF_CNT_EN
    logic [3:0]            cnt_ev;
    logic [3:0][CNT_W-1:0] cnt;

    // Events count only when they win priority in that cycle.
    assign cnt_ev[0] = load_hz && !mem_stall && !PCSrcE;
    assign cnt_ev[1] = div_hz && !mem_stall && !PCSrcE;
    assign cnt_ev[2] = mem_stall;
    assign cnt_ev[3] = PCSrcE && !mem_stall;

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        hsu_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (cnt_ev[g]),
            .cnt_o (cnt[g])
        );
    end

    assign LoadStallCnt = cnt[0];
    assign DivStallCnt  = cnt[1];
    assign MemStallCnt  = cnt[2];
    assign FlushCnt     = cnt[3];
`else
    assign LoadStallCnt = '0;
    assign DivStallCnt  = '0;
    assign MemStallCnt  = '0;
    assign FlushCnt     = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed-vector bench for hazard_scoreboard_unit; counter expectations follow HAZARD_PERF_CNT_EN.

module tb_hazard_scoreboard_unit;
    localparam int AW = 5;
    localparam int CW = 3;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, DivRdW;
    logic          RegWriteD, IsDivD, PCSrcE, ResultSrcE0, DivStartE;
    logic          RegWriteM, RegWriteW, MemReqM, MemReadyM, DivValidW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          Forwardr1D, Forwardr2D;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [CW-1:0] LoadStallCnt, DivStallCnt, MemStallCnt, FlushCnt;
    logic          DivBusy;
    logic [6:0]    ctl;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_HZ   = 7'b1100010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_MEM  = 7'b1111001;

    hazard_scoreboard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .IsDivD(IsDivD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .PCSrcE(PCSrcE), .ResultSrcE0(ResultSrcE0), .DivStartE(DivStartE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .DivValidW(DivValidW), .DivRdW(DivRdW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .Forwardr1D(Forwardr1D), .Forwardr2D(Forwardr2D),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .LoadStallCnt(LoadStallCnt), .DivStallCnt(DivStallCnt),
        .MemStallCnt(MemStallCnt), .FlushCnt(FlushCnt),
        .DivBusy(DivBusy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0; IsDivD = 1'b0;
        Rs1E = '0; Rs2E = '0; RdE = '0;
        PCSrcE = 1'b0; ResultSrcE0 = 1'b0; DivStartE = 1'b0;
        RdM = '0; RdW = '0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemReqM = 1'b0; MemReadyM = 1'b1;
        DivValidW = 1'b0; DivRdW = '0;
    endtask

    // Every edge also checks that no divide is issued while one is in flight.
    task automatic tick();
        check("start_while_busy", {31'd0, rst_n && DivStartE && DivBusy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic cnts(input string tag, input int ld, input int dv, input int mm, input int fl);
        check({tag, "_ldcnt"}, LoadStallCnt, PERF ? ld : 0);
        check({tag, "_dvcnt"}, DivStallCnt,  PERF ? dv : 0);
        check({tag, "_mmcnt"}, MemStallCnt,  PERF ? mm : 0);
        check({tag, "_flcnt"}, FlushCnt,     PERF ? fl : 0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_divbusy", DivBusy, 0);
        check("rst_ctl", ctl, C_NONE);
        check("rst_fwd", {ForwardAE, ForwardBE}, 0);
        cnts("rst", 0, 0, 0, 0);
        tick();

        // load x5 in E, add x6,x5,x1 in D
        idle(); ResultSrcE0 = 1'b1; RdE = 5; Rs1D = 5; Rs2D = 1; RegWriteD = 1'b1; RdD = 6;
        #1 check("ld_ctl", ctl, C_HZ);
        tick();
        idle(); Rs1E = 5; Rs2E = 1; RdW = 5; RegWriteW = 1'b1;
        #1 check("ld_fwdA", ForwardAE, 2'b01);
        check("ld_fwdB", ForwardBE, 2'b00);
        check("ld_ctl2", ctl, C_NONE);
        check("ld_cnt", LoadStallCnt, PERF ? 1 : 0);
        tick();

        // forwarding priority and x0 boundary
        idle(); RdM = 3; RegWriteM = 1'b1; RdW = 3; RegWriteW = 1'b1;
        Rs1E = 3; Rs2E = 0; Rs1D = 3; Rs2D = 0;
        #1 check("fwd_mprio", ForwardAE, 2'b10);
        check("fwd_x0B", ForwardBE, 2'b00);
        check("fwd_r1D", Forwardr1D, 1);
        check("fwd_r2D_x0", Forwardr2D, 0);
        idle(); RdM = 0; RegWriteM = 1'b1; Rs2E = 0; RdW = 0; RegWriteW = 1'b1; Rs2D = 0;
        #1 check("fwd_rdm0", ForwardBE, 2'b00);
        check("fwd_rdw0_d", Forwardr2D, 0);
        idle(); RdM = 4; RegWriteM = 1'b0; RdW = 4; RegWriteW = 1'b1; Rs1E = 4; Rs2E = 4;
        #1 check("fwd_wonly", {ForwardAE, ForwardBE}, 4'b0101);
        tick();

        // div x7 issues with dependent in D
        idle(); DivStartE = 1'b1; RdE = 7; Rs1D = 7; RegWriteD = 1'b1; RdD = 8;
        #1 check("div_issue_ctl", ctl, C_HZ);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(); RegWriteD = 1'b1;
            if (i == 1) begin Rs1D = 1; RdD = 7; end
            else begin Rs1D = 7; RdD = 8; end
            #1 check("div_busy_ctl", ctl, C_HZ);
            check("div_busy", DivBusy, 1);
            tick();
        end
        idle(); IsDivD = 1'b1; RegWriteD = 1'b1; RdD = 10; Rs1D = 1; Rs2D = 2;
        #1 check("div2_ctl", ctl, C_HZ);
        tick();
        idle(); Rs1D = 7; RegWriteD = 1'b1; RdD = 8; DivValidW = 1'b1; DivRdW = 7;
        #1 check("divw_ctl", ctl, C_HZ);
        tick();
        idle(); Rs1D = 7; RegWriteD = 1'b1; RdD = 8;
        #1 check("div_done_ctl", ctl, C_NONE);
        check("div_done_busy", DivBusy, 0);
        cnts("div", 1, 6, 0, 0);
        tick();

        // taken branch overrides load-use
        idle(); PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RdE = 5; Rs1D = 5;
        #1 check("br_ctl", ctl, C_BR);
        tick();
        idle();
        #1 cnts("br", 1, 6, 0, 1);

        // memory not ready for 3 cycles with a branch and a blocked divide
        for (int i = 0; i < 3; i++) begin
            idle(); MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
            DivStartE = 1'b1; RdE = 12; Rs1D = 12;
            #1 check("mem_ctl", ctl, C_MEM);
            tick();
        end
        idle(); MemReqM = 1'b1; MemReadyM = 1'b1; PCSrcE = 1'b1;
        #1 check("mem_rel_ctl", ctl, C_BR);
        check("mem_no_div", DivBusy, 0);
        tick();
        idle();
        #1 cnts("mem", 1, 6, 3, 2);

        // load-use held long enough to saturate the 3-bit counter
        for (int i = 0; i < 8; i++) begin
            idle(); ResultSrcE0 = 1'b1; RdE = 2; Rs2D = 2;
            #1 tick();
        end
        idle();
        #1 check("sat_ldcnt", LoadStallCnt, PERF ? 7 : 0);

        // reset while a divide to x9 is in flight
        idle(); DivStartE = 1'b1; RdE = 9;
        #1 tick();
        idle(); Rs1D = 9;
        #1 check("pre_rst_busy", DivBusy, 1);
        check("pre_rst_ctl", ctl, C_HZ);
        rst_n = 1'b0;
        #1 check("in_rst_ctl", ctl, C_NONE);
        tick();
        rst_n = 1'b1;
        #1 check("post_rst_busy", DivBusy, 0);
        check("post_rst_ctl", ctl, C_NONE);
        cnts("post_rst", 0, 0, 0, 0);
        idle(); DivValidW = 1'b1; DivRdW = 9; Rs1D = 9;
        #1 check("late_valid_ctl", ctl, C_NONE);
        tick();
        idle(); Rs1D = 9;
        #1 check("late_valid_busy", DivBusy, 0);

        // divide targeting x0 never marks x0 busy
        idle(); DivStartE = 1'b1; RdE = 0; Rs1D = 0; RegWriteD = 1'b1; RdD = 0;
        #1 check("x0_issue_ctl", ctl, C_NONE);
        tick();
        idle(); Rs1D = 0; RegWriteD = 1'b1; RdD = 0;
        #1 check("x0_ctl", ctl, C_NONE);
        check("x0_divbusy", DivBusy, 1);
        IsDivD = 1'b1;
        #1 check("x0_div2_ctl", ctl, C_HZ);
        tick();
        idle(); DivValidW = 1'b1; DivRdW = 0;
        #1 tick();
        idle();
        #1 check("x0_done_busy", DivBusy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
